// File: rtl/lc_1512_good_pairs_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lc_pairs_pkg
// Description : Shared FSM encoding, default widths and saturating adder for
//               the framed good-pairs counter.
// Revision    : 1.0 - initial release
// ============================================================================
package lc_pairs_pkg;

    localparam int DEF_KEY_W   = 8;
    localparam int DEF_CNT_W   = 16;
    localparam int DEF_PAIRS_W = 32;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Unsigned add clamped to 2**w-1; valid for result widths up to 63 bits.
    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input int unsigned w);
        logic [64:0] sum;
        logic [64:0] max;
        sum = {1'b0, a} + {1'b0, b};
        max = (65'd1 << w) - 65'd1;
        if (sum > max) begin
            return max[63:0];
        end
        return sum[63:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/lc_1512_good_pairs_stream_if.sv
`default_nettype none
// ============================================================================
// Module      : lc_1512_good_pairs_stream_if
// Description : Keyed input stream and pair-count result stream.
// Revision    : 1.0 - initial release
// ============================================================================
interface lc_1512_good_pairs_stream_if
    import lc_pairs_pkg::*;
#(
    parameter int KEY_W   = DEF_KEY_W,
    parameter int PAIRS_W = DEF_PAIRS_W
) ();

    logic [KEY_W-1:0]   in_tdata;
    logic               in_tvalid;
    logic               in_tlast;
    logic               in_tready;
    logic [PAIRS_W-1:0] out_tdata;
    logic               out_tvalid;
    logic               out_tready;

    modport master (
        output in_tdata, in_tvalid, in_tlast, out_tready,
        input  in_tready, out_tdata, out_tvalid
    );

    modport slave (
        input  in_tdata, in_tvalid, in_tlast, out_tready,
        output in_tready, out_tdata, out_tvalid
    );

endinterface
`default_nettype wire

// File: rtl/lc_1512_good_pairs_stream_count_table.sv
`default_nettype none
// ============================================================================
// Module      : lc_pairs_count_table
// Description : 2**KEY_W x CNT_W occurrence table, combinational read, one
//               write port and a sequential one-entry-per-cycle clear sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module lc_pairs_count_table
    import lc_pairs_pkg::*;
#(
    parameter int KEY_W = DEF_KEY_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             clr_en,
    output logic                  clr_last,
    input  wire logic [KEY_W-1:0] rd_addr,
    output logic      [CNT_W-1:0] rd_data,
    input  wire logic             wr_en,
    input  wire logic [KEY_W-1:0] wr_addr,
    input  wire logic [CNT_W-1:0] wr_data
);

    localparam int c_depth = 2 ** KEY_W;

    logic [CNT_W-1:0] r_mem [c_depth];
    logic [KEY_W-1:0] r_clr_addr;

    // The address wraps back to 0 after the last entry, ready for the next sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clr_addr <= '0;
        end else if (clr_en) begin
            r_clr_addr <= r_clr_addr + KEY_W'(1);
        end
    end

    // Contents need no reset: every path out of reset passes through a full sweep.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_en) begin
                r_mem[r_clr_addr] <= '0;
            end else if (wr_en) begin
                r_mem[wr_addr] <= wr_data;
            end
        end
    end

    assign clr_last = &r_clr_addr;
    assign rd_data  = r_mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/lc_1512_good_pairs_stream.sv
`default_nettype none
// ============================================================================
// Module      : lc_1512_good_pairs_stream
// Description : Per-frame count of equal-key index pairs (i<j) on a tlast-
//               framed stream. Define LC_PAIRS_SATURATE_EN to clamp the pair
//               count at 2**PAIRS_W-1 instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module lc_1512_good_pairs_stream
    import lc_pairs_pkg::*;
#(
    parameter int KEY_W   = DEF_KEY_W,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int PAIRS_W = DEF_PAIRS_W
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    lc_1512_good_pairs_stream_if.slave  bus
);

    state_t             r_state;
    logic               r_in_tready;
    logic               r_out_tvalid;
    logic [PAIRS_W-1:0] r_out_tdata;
    logic [PAIRS_W-1:0] r_pairs;

    logic               w_accept;
    logic               w_clr_en;
    logic               w_clr_last;
    logic [CNT_W-1:0]   w_rd_data;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [PAIRS_W-1:0] w_sum;

    assign w_accept  = r_in_tready & bus.in_tvalid;
    assign w_clr_en  = (r_state == ST_CLEAR);
    assign w_cnt_inc = CNT_W'(sat_add(64'(w_rd_data), 64'd1, CNT_W));

    // Existing occurrences of k each form one new pair with the incoming beat.
`ifdef LC_PAIRS_SATURATE_EN
    assign w_sum = PAIRS_W'(sat_add(64'(r_pairs), 64'(w_rd_data), PAIRS_W));
`else
    assign w_sum = r_pairs + PAIRS_W'(w_rd_data);
`endif

    lc_pairs_count_table #(
        .KEY_W (KEY_W),
        .CNT_W (CNT_W)
    ) u_table (
        .clk      (clk),
        .rst      (rst),
        .clr_en   (w_clr_en),
        .clr_last (w_clr_last),
        .rd_addr  (bus.in_tdata),
        .rd_data  (w_rd_data),
        .wr_en    (w_accept),
        .wr_addr  (bus.in_tdata),
        .wr_data  (w_cnt_inc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_CLEAR;
            r_in_tready  <= 1'b0;
            r_out_tvalid <= 1'b0;
            r_out_tdata  <= '0;
            r_pairs      <= '0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    if (w_clr_last) begin
                        r_state     <= ST_RUN;
                        r_in_tready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_accept) begin
                        if (bus.in_tlast) begin
                            r_out_tdata  <= w_sum;
                            r_out_tvalid <= 1'b1;
                            r_pairs      <= '0;
                            r_in_tready  <= 1'b0;
                            r_state      <= ST_DONE;
                        end else begin
                            r_pairs <= w_sum;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.out_tready) begin
                        r_out_tvalid <= 1'b0;
                        r_state      <= ST_CLEAR;
                    end
                end
                default: begin
                    r_state     <= ST_CLEAR;
                    r_in_tready <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_tready  = r_in_tready;
    assign bus.out_tvalid = r_out_tvalid;
    assign bus.out_tdata  = r_out_tdata;

endmodule
`default_nettype wire

// File: tb/tb_lc_1512_good_pairs_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_lc_1512_good_pairs_stream
// Description : Directed frame table plus reset-abort and narrow-accumulator
//               sequences for the good-pairs counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lc_1512_good_pairs_stream;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lc_1512_good_pairs_stream_if #(.KEY_W(8), .PAIRS_W(32)) bus  ();
    lc_1512_good_pairs_stream_if #(.KEY_W(8), .PAIRS_W(4))  bus4 ();

    lc_1512_good_pairs_stream #(.KEY_W(8), .CNT_W(16), .PAIRS_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    lc_1512_good_pairs_stream #(.KEY_W(8), .CNT_W(16), .PAIRS_W(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    typedef struct {
        int          n;
        logic [7:0]  keys [12];
        logic [31:0] exp;
        bit          gap;
        int          hold;
    } vec_t;

    vec_t vt [6];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Caller sits at a negedge; counts negedges (including this one) with in_tready low.
    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (bus.in_tready !== 1'b1 && cnt < 2000) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic run_frame(input int idx);
        int cnt;
        wait_ready(cnt);
        check($sformatf("ready_gap[%0d]", idx), 32'(cnt), 32'd256);
        for (int b = 0; b < vt[idx].n; b++) begin
            bus.in_tvalid = 1'b1;
            bus.in_tdata  = vt[idx].keys[b];
            bus.in_tlast  = (b == vt[idx].n - 1);
            if (b == vt[idx].n - 1) begin
                check($sformatf("ready_last[%0d]", idx), 32'(bus.in_tready), 32'd1);
                check($sformatf("early_valid[%0d]", idx), 32'(bus.out_tvalid), 32'd0);
            end
            @(posedge clk);
            @(negedge clk);
            if (vt[idx].gap && b != vt[idx].n - 1) begin
                bus.in_tvalid = 1'b0;
                bus.in_tdata  = 8'($urandom);
                bus.in_tlast  = 1'b1;
                @(posedge clk);
                @(negedge clk);
            end
        end
        bus.in_tvalid = 1'b0;
        bus.in_tlast  = 1'b0;
        check($sformatf("latency_valid[%0d]", idx), 32'(bus.out_tvalid), 32'd1);
        check($sformatf("result[%0d]", idx), bus.out_tdata, vt[idx].exp);
        check($sformatf("done_ready[%0d]", idx), 32'(bus.in_tready), 32'd0);
        for (int h = 0; h < vt[idx].hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("hold_valid[%0d]", idx), 32'(bus.out_tvalid), 32'd1);
            check($sformatf("hold_data[%0d]", idx), bus.out_tdata, vt[idx].exp);
            check($sformatf("hold_ready[%0d]", idx), 32'(bus.in_tready), 32'd0);
        end
        bus.out_tready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_tready = 1'b0;
        check($sformatf("valid_drop[%0d]", idx), 32'(bus.out_tvalid), 32'd0);
    endtask

    initial begin
        int cnt;
        bus.in_tvalid  = 1'b0;
        bus.in_tdata   = '0;
        bus.in_tlast   = 1'b0;
        bus.out_tready = 1'b0;
        bus4.in_tvalid  = 1'b0;
        bus4.in_tdata   = '0;
        bus4.in_tlast   = 1'b0;
        bus4.out_tready = 1'b0;

        vt[0] = '{n: 12, keys: '{5, 123, 5, 3, 5, 4, 2, 1, 0, 26, 255, 255}, exp: 32'd4, gap: 1'b0, hold: 0};
        vt[1] = '{n: 4,  keys: '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0},       exp: 32'd6, gap: 1'b0, hold: 0};
        vt[2] = '{n: 2,  keys: '{1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0},       exp: 32'd0, gap: 1'b0, hold: 0};
        vt[3] = '{n: 1,  keys: '{7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0},       exp: 32'd0, gap: 1'b0, hold: 3};
        vt[4] = '{n: 3,  keys: '{9, 9, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0},       exp: 32'd3, gap: 1'b1, hold: 0};
        vt[5] = '{n: 2,  keys: '{4, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0},       exp: 32'd0, gap: 1'b0, hold: 1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_in_tready", 32'(bus.in_tready), 32'd0);
        check("reset_out_tvalid", 32'(bus.out_tvalid), 32'd0);
        check("reset_out_tdata", bus.out_tdata, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_frame(i);
        end

        // Abort a frame after two beats; the table must be swept again.
        wait_ready(cnt);
        check("ready_gap_pre_abort", 32'(cnt), 32'd256);
        for (int b = 0; b < 2; b++) begin
            bus.in_tvalid = 1'b1;
            bus.in_tdata  = 8'd4;
            bus.in_tlast  = 1'b0;
            @(posedge clk);
            @(negedge clk);
        end
        bus.in_tvalid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort_in_tready", 32'(bus.in_tready), 32'd0);
        check("abort_out_tvalid", 32'(bus.out_tvalid), 32'd0);
        check("abort_out_tdata", bus.out_tdata, 32'd0);
        run_frame(5);

        // Narrow accumulator: seven equal keys give 21 pairs.
        cnt = 0;
        while (bus4.in_tready !== 1'b1 && cnt < 2000) begin
            cnt++;
            @(negedge clk);
        end
        check("p4_ready", 32'(bus4.in_tready), 32'd1);
        for (int b = 0; b < 7; b++) begin
            bus4.in_tvalid = 1'b1;
            bus4.in_tdata  = 8'd3;
            bus4.in_tlast  = (b == 6);
            @(posedge clk);
            @(negedge clk);
        end
        bus4.in_tvalid = 1'b0;
        bus4.in_tlast  = 1'b0;
        check("p4_valid", 32'(bus4.out_tvalid), 32'd1);
`ifdef LC_PAIRS_SATURATE_EN
        check("p4_result", 32'(bus4.out_tdata), 32'd15);
`else
        check("p4_result", 32'(bus4.out_tdata), 32'd5);
`endif
        bus4.out_tready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus4.out_tready = 1'b0;
        check("p4_valid_drop", 32'(bus4.out_tvalid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
